// File: rtl/instruction_memory_sync_if.sv
// Fetch and program-load bus for instruction_memory_sync.
// master: fetch stage / loader side; slave: the memory.
interface instruction_memory_sync_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  ready;
    logic                  fetch_req;
    logic [ADDR_WIDTH+1:0] fetch_addr;
    logic                  fetch_stall;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_valid;
    logic                  fetch_misaligned;
    logic                  load_we;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;

    modport master (
        input  ready,
        input  fetch_data,
        input  fetch_valid,
        input  fetch_misaligned,
        output fetch_req,
        output fetch_addr,
        output fetch_stall,
        output load_we,
        output load_addr,
        output load_data
    );

    modport slave (
        output ready,
        output fetch_data,
        output fetch_valid,
        output fetch_misaligned,
        input  fetch_req,
        input  fetch_addr,
        input  fetch_stall,
        input  load_we,
        input  load_addr,
        input  load_data
    );
endinterface

// File: rtl/instruction_memory_sync.sv
// Synchronous instruction memory: clear sweep after reset, 1-cycle fetch.
// Ports: clk, rst_n (async active-low), bus (slave: fetch + load + ready).
module instruction_memory_sync #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    instruction_memory_sync_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_mis_q, fetch_mis_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data;

    // Write port is shared between the clear sweep and program load.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ram_we    = 1'b0;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_we    = bus.load_we;
                ram_waddr = bus.load_addr;
                ram_wdata = bus.load_data;
            end
            default: ;
        endcase
    end

    // Write-first: a same-edge write to the fetched word is forwarded.
    assign rd_word = bus.fetch_addr[ADDR_WIDTH+1:2];
    assign rd_data = (ram_we && ram_waddr == rd_word) ? ram_wdata
                                                      : mem[rd_word];

    always_comb begin
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = fetch_valid_q;
        fetch_mis_d   = fetch_mis_q;
        if (state_q == CLEAR) begin
            fetch_data_d  = '0;
            fetch_valid_d = 1'b0;
            fetch_mis_d   = 1'b0;
        end else if (!bus.fetch_stall) begin
            if (bus.fetch_req) begin
                fetch_valid_d = 1'b1;
                if (bus.fetch_addr[1:0] != 2'b00) begin
                    fetch_data_d = '0;
                    fetch_mis_d  = 1'b1;
                end else begin
                    fetch_data_d = rd_data;
                    fetch_mis_d  = 1'b0;
                end
            end else begin
                fetch_valid_d = 1'b0;
                fetch_mis_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLEAR;
            clr_cnt_q     <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            fetch_mis_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_mis_q   <= fetch_mis_d;
        end
    end

    // Array has no reset; the sweep provides the all-NOP image.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    assign bus.ready            = (state_q == RUN);
    assign bus.fetch_data       = fetch_data_q;
    assign bus.fetch_valid      = fetch_valid_q;
    assign bus.fetch_misaligned = fetch_mis_q;
endmodule
